// File: rtl/timing_pkg.sv
// Shared timing-path definitions used by the decoder, the timing queue and
// the timing control unit.
package timing_pkg;

  localparam int TRG_WORD_W         = 8;
  localparam int TIMING_QUEUE_DEPTH = 16;

  typedef logic [TRG_WORD_W-1:0] trg_word_t;

endpackage

// File: rtl/timing_queue_ctrl.sv
// Pointer, occupancy and status-flag control for the timing queue.
// Optional sticky overflow/underflow flags when TIMING_QUEUE_ERR_FLAGS_EN is defined.
module timing_queue_ctrl
  import timing_pkg::*;
#(
  parameter int  DEPTH     = TIMING_QUEUE_DEPTH,
  parameter int  AF_THRESH = DEPTH - 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          re,
`ifdef TIMING_QUEUE_ERR_FLAGS_EN
  input  logic          err_clr,
  output logic          overflow,
  output logic          underflow,
`endif
  output logic          push,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          almost_full,
  output logic          fifo_empty
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);

  logic        pop;
  logic [AW:0] next_count;

  // A pop frees a slot in the same cycle, so a full queue still accepts a write alongside it.
  assign pop  = re && !fifo_empty;
  assign push = wr_en && (!full || pop);

  always_comb begin
    next_count = count;
    case ({push, pop})
      2'b10:   next_count = count + 1'b1;
      2'b01:   next_count = count - 1'b1;
      default: next_count = count;
    endcase
  end

  // Flags are registered from next_count so they line up with the updated count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fifo_empty  <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= next_count;
      fifo_empty  <= (next_count == '0);
      full        <= (next_count == DEPTH_C);
      almost_full <= (next_count >= AF_C);
    end
  end

`ifdef TIMING_QUEUE_ERR_FLAGS_EN
  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !re) overflow <= 1'b1;
      else if (err_clr)         overflow <= 1'b0;
      if (re && fifo_empty)     underflow <= 1'b1;
      else if (err_clr)         underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/timing_queue_fifo.sv
// First-word-fall-through trigger-word queue between decoder and timing control unit.
// Defining TIMING_QUEUE_ERR_FLAGS_EN adds err_clr and sticky overflow/underflow ports.
module timing_queue_fifo
  import timing_pkg::*;
#(
  parameter int  DW        = TRG_WORD_W,
  parameter int  DEPTH     = TIMING_QUEUE_DEPTH,
  parameter int  AF_THRESH = DEPTH - 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          almost_full,
  input  logic          re,
  output logic [DW-1:0] trg_wrd,
  output logic          fifo_empty,
`ifdef TIMING_QUEUE_ERR_FLAGS_EN
  input  logic          err_clr,
  output logic          overflow,
  output logic          underflow,
`endif
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;

  timing_queue_ctrl #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .re          (re),
`ifdef TIMING_QUEUE_ERR_FLAGS_EN
    .err_clr     (err_clr),
    .overflow    (overflow),
    .underflow   (underflow),
`endif
    .push        (push),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count),
    .full        (full),
    .almost_full (almost_full),
    .fifo_empty  (fifo_empty)
  );

  // Storage is deliberately not reset; emptiness gates the read side instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign trg_wrd = fifo_empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_timing_queue_fifo.sv
// Self-checking bench for timing_queue_fifo: queue-based reference model plus
// directed scenarios; covers the TIMING_QUEUE_ERR_FLAGS_EN ports when defined.
module tb_timing_queue_fifo;
  import timing_pkg::*;

  localparam int DEPTH = TIMING_QUEUE_DEPTH;
  localparam int AF    = DEPTH - 2;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      wr_en = 1'b0;
  logic      re = 1'b0;
  trg_word_t wr_data = '0;
  logic      err_clr = 1'b0;
  logic      full, almost_full, fifo_empty;
  trg_word_t trg_wrd;
  logic [$clog2(DEPTH):0] count;
`ifdef TIMING_QUEUE_ERR_FLAGS_EN
  logic      overflow, underflow;
`endif

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  trg_word_t model_q[$];
  bit m_ov = 1'b0, m_un = 1'b0;
  bit m_empty, m_full, m_pop, m_push;

  always #5 clk = ~clk;

  timing_queue_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .almost_full (almost_full),
    .re          (re),
    .trg_wrd     (trg_wrd),
    .fifo_empty  (fifo_empty),
`ifdef TIMING_QUEUE_ERR_FLAGS_EN
    .err_clr     (err_clr),
    .overflow    (overflow),
    .underflow   (underflow),
`endif
    .count       (count)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit w, input trg_word_t d, input bit r, input bit c = 1'b0);
    @(negedge clk);
    wr_en = w; wr_data = d; re = r; err_clr = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0; re = 1'b0; err_clr = 1'b0;
  endtask

  // Reference model: an ordered queue of accepted words, updated per clock.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      m_empty = (model_q.size() == 0);
      m_full  = (model_q.size() == DEPTH);
      m_pop   = re && !m_empty;
      m_push  = wr_en && (!m_full || m_pop);
      if (wr_en && m_full && !re) m_ov = 1'b1;
      else if (err_clr)           m_ov = 1'b0;
      if (re && m_empty)          m_un = 1'b1;
      else if (err_clr)           m_un = 1'b0;
      if (m_pop)  void'(model_q.pop_front());
      if (m_push) model_q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("model_count", 32'(count), model_q.size());
      checkOutput("model_empty", 32'(fifo_empty), 32'(model_q.size() == 0));
      checkOutput("model_full", 32'(full), 32'(model_q.size() == DEPTH));
      checkOutput("model_af", 32'(almost_full), 32'(model_q.size() >= AF));
      checkOutput("model_trg", 32'(trg_wrd), (model_q.size() == 0) ? 32'h0 : 32'(model_q[0]));
`ifdef TIMING_QUEUE_ERR_FLAGS_EN
      checkOutput("model_overflow", 32'(overflow), 32'(m_ov));
      checkOutput("model_underflow", 32'(underflow), 32'(m_un));
`endif
    end
  end

  initial begin
    trg_word_t exp_w;

    #1 rst = 1'b0;
    #12;
    checkOutput("rst_empty", 32'(fifo_empty), 32'h1);
    checkOutput("rst_full", 32'(full), 32'h0);
    checkOutput("rst_af", 32'(almost_full), 32'h0);
    checkOutput("rst_count", 32'(count), 32'h0);
    checkOutput("rst_trg", 32'(trg_wrd), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    checking = 1'b1;

    // Popping an empty queue changes nothing.
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("idle_re_count", 32'(count), 32'h0);
    checkOutput("idle_re_empty", 32'(fifo_empty), 32'h1);
`ifdef TIMING_QUEUE_ERR_FLAGS_EN
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
`endif

    applyStimulus(1'b1, 8'h81, 1'b0);
    checkOutput("w1_trg", 32'(trg_wrd), 32'h81);
    checkOutput("w1_count", 32'(count), 32'h1);
    applyStimulus(1'b1, 8'h03, 1'b0);
    checkOutput("w2_count", 32'(count), 32'h2);
    checkOutput("w2_trg", 32'(trg_wrd), 32'h81);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("p1_trg", 32'(trg_wrd), 32'h03);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("p2_empty", 32'(fifo_empty), 32'h1);
    checkOutput("p2_trg", 32'(trg_wrd), 32'h0);

    // Fill to full, then try a dropped write.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, trg_word_t'(i), 1'b0);
      if (i == 12) checkOutput("fill_af_13", 32'(almost_full), 32'h0);
      if (i == 13) checkOutput("fill_af_14", 32'(almost_full), 32'h1);
      if (i == 14) checkOutput("fill_full_15", 32'(full), 32'h0);
    end
    checkOutput("fill_full", 32'(full), 32'h1);
    checkOutput("fill_count", 32'(count), 32'd16);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("drop_count", 32'(count), 32'd16);
    checkOutput("drop_trg", 32'(trg_wrd), 32'h00);
`ifdef TIMING_QUEUE_ERR_FLAGS_EN
    checkOutput("ovf_set", 32'(overflow), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf_clr", 32'(overflow), 32'h0);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("drain_order", 32'(trg_wrd), 32'(i));
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("drain_empty", 32'(fifo_empty), 32'h1);

    // Full queue with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, trg_word_t'(i), 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b1);
    checkOutput("fullpp_count", 32'(count), 32'd16);
    checkOutput("fullpp_trg", 32'(trg_wrd), 32'h01);
    for (int i = 0; i < DEPTH; i++) begin
      exp_w = (i < DEPTH - 1) ? trg_word_t'(i + 1) : 8'hAA;
      checkOutput("fullpp_drain", 32'(trg_wrd), 32'(exp_w));
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("fullpp_empty", 32'(fifo_empty), 32'h1);

    // Empty queue with simultaneous push and pop.
    applyStimulus(1'b1, 8'h55, 1'b1);
    checkOutput("emptypp_count", 32'(count), 32'h1);
    checkOutput("emptypp_trg", 32'(trg_wrd), 32'h55);
`ifdef TIMING_QUEUE_ERR_FLAGS_EN
    checkOutput("unf_set", 32'(underflow), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("unf_clr", 32'(underflow), 32'h0);
`endif
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("emptypp_pop", 32'(fifo_empty), 32'h1);

    // Asynchronous reset in the middle of a cycle.
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    checkOutput("pre_rst_count", 32'(count), 32'h3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_count", 32'(count), 32'h0);
    checkOutput("async_rst_empty", 32'(fifo_empty), 32'h1);
    checkOutput("async_rst_trg", 32'(trg_wrd), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h42, 1'b0);
    checkOutput("post_rst_trg", 32'(trg_wrd), 32'h42);
    checkOutput("post_rst_count", 32'(count), 32'h1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timing_queue_fifo.md
Name: timing_queue_fifo

Overview:
- Timing queue between the instruction decoder and the timing control unit.
- Buffers 8-bit trigger words written by the decoder.
- Presents the oldest word first-word-fall-through (FWFT): the head word is valid on trg_wrd whenever fifo_empty=0, and the consumer pops it with re.
- Sits directly upstream of the timing control unit and drives its trg_wrd and fifo_empty inputs.

Parameters:
- DW, 8, trigger word width in bits.
- DEPTH, 16, number of entries; must be a power of 2, >= 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.
- AF_THRESH, DEPTH-2, occupancy at or above which almost_full asserts.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- wr_en  input  1  write request from decoder.
- wr_data  input  DW  trigger word to enqueue.
- full  output  1  queue holds DEPTH entries.
- almost_full  output  1  count >= AF_THRESH.
- re  input  1  pop request from the timing control unit.
- trg_wrd  output  DW  head-of-queue word (FWFT).
- fifo_empty  output  1  queue holds 0 entries.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x DW register array; wr_ptr and rd_ptr are AW bits; count register is AW+1 bits.
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - fifo_empty=1, full=0, almost_full=0, trg_wrd=0.
  - Array contents are not reset.
- Release of reset is synchronous to clk; the first write is accepted on the first rising edge with rst=1.
- Accept conditions:
  - push = wr_en && (!full || pop).
  - pop = re && !fifo_empty.
  - The full-with-pop case is a same-cycle pop+push: the write is accepted.
- On push: mem[wr_ptr] <= wr_data; wr_ptr increments modulo DEPTH (natural wrap, AW bits).
- On pop: rd_ptr increments modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Flags are registered and derived from next-count, so they are valid the cycle after the edge:
  - fifo_empty = (count==0).
  - full = (count==DEPTH).
  - almost_full = (count>=AF_THRESH).
- trg_wrd = mem[rd_ptr] when !fifo_empty, else 0.
  - Combinational read from the array; no pipeline stage.
- Latency: a word written into an empty queue at edge N is visible on trg_wrd with fifo_empty=0 after edge N. It can be popped at edge N+1 at the earliest.
- Boundary conditions:
  - re while empty: ignored; no pointer or count change.
  - wr_en while full without pop: dropped; no state change.
  - wr_en and re together on empty: write accepted; re ignored; count becomes 1.
  - wr_en and re together on full: both accepted; count stays DEPTH; the popped word is the old head.
  - Pointer wrap from DEPTH-1 to 0 is seamless.
  - Reset mid-operation: queue is emptied immediately; stored words are discarded.
- No X on any output after reset.

Optional Feature:
- Macro: TIMING_QUEUE_ERR_FLAGS_EN.
- When defined, three ports are added:
  - err_clr (input, 1).
  - overflow (output, 1): sticky; set when wr_en && full && !re.
  - underflow (output, 1): sticky; set when re && fifo_empty.
  - Both flags clear on err_clr=1 or reset.
  - If a set event and err_clr occur in the same cycle, set wins.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package timing_pkg holds:
  - TRG_WORD_W=8.
  - TIMING_QUEUE_DEPTH=16.
  - typedef trg_word_t (logic [TRG_WORD_W-1:0]).
  - The same package is also used by the decoder and the timing control unit.
- One natural sub-module: timing_queue_ctrl.
  - Contains pointers, count, flag registers and the push/pop decode.
  - The top level instantiates it alongside the storage array.

Test Plan:
- Reset then idle -> fifo_empty=1, full=0, count=0, trg_wrd=0; re=1 for 3 cycles causes no change.
- Write 8'h81 then 8'h03 on consecutive cycles -> trg_wrd=8'h81 and count=1 after the first edge; count=2 after the second; re pops 8'h81, then 8'h03; fifo_empty=1 after the second pop.
- Fill with 16 words 8'h00..8'h0F -> almost_full=1 at count=14; full=1 at count=16; a 17th write of 8'hFF is dropped; drain returns 8'h00..8'h0F in order.
- Queue full, wr_en=1 with 8'hAA and re=1 together -> head 8'h00 popped, count stays 16, 8'hAA becomes the last word out.
- Queue empty, wr_en=1 with 8'h55 and re=1 together -> count=1, trg_wrd=8'h55 the next cycle; with TIMING_QUEUE_ERR_FLAGS_EN, underflow=1, and err_clr clears it.
- Write 3 words, assert rst=0 asynchronously mid-cycle -> fifo_empty=1 and count=0 immediately, without waiting for a clock edge; after release, a new write 8'h42 is the head.
